denoise_stream: RTL and testbench

//   Parametrised successor to the fixed 8-bit denoise stage. Applies a 3-tap horizontal filter,

---
 rtl/denoise_stream.sv | 155 +++++++++++++++
 tb/tb_denoise_stream.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/denoise_stream.sv
// 3-tap horizontal denoise (bypass / median-of-3 / 1-2-1 mean) on a channel-serial pixel stream.
// Edge pixels are replicated so every input pixel produces exactly one output pixel.
module denoise_stream #(
  parameter int DATA_W = 8,
  parameter int CH     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              valid_in,
  input  logic [2:0]        color_in,
  input  logic              last_in,
  input  logic [1:0]        mode_in,
  output logic              in_ready,
  output logic [DATA_W-1:0] pixel_out,
  output logic              valid_out,
  output logic [2:0]        color_out,
  output logic              last_out,
  output logic              err,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_e;

  localparam int              CW      = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [2:0]      VOID    = 3'(CH);
  localparam logic [CW-1:0]   CH_LAST = CW'(CH - 1);

  state_e            state_q;
  logic [CW-1:0]     ch_q;
  logic [1:0]        mode_q;
  logic              last_any_q, last_all_q;
  logic [DATA_W-1:0] prv_q [CH];
  logic [DATA_W-1:0] cur_q [CH];
  logic [DATA_W-1:0] pixel_out_q;
  logic              valid_out_q, last_out_q, err_q;
  logic [2:0]        color_out_q;

  function automatic logic [DATA_W-1:0] filt(input logic [1:0] m, input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c);
    logic [DATA_W-1:0] lo, hi;
    logic [DATA_W+1:0] sum;
    lo  = (a < b) ? a : b;
    hi  = (a < b) ? b : a;
    sum = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + (DATA_W+2)'(2);
    case (m)
      2'b01:   filt = (c < lo) ? lo : ((c > hi) ? hi : c);
      2'b10:   filt = sum[DATA_W+1:2];
      default: filt = b;
    endcase
  endfunction

  // Handshake: a sample is taken on a rising edge when valid_in & in_ready and color_in
  // names the next expected channel; VOID codes are ignored, anything else is an error.
  logic              is_chan, hit, in_order, acc, bad, end_px, last_any_d, last_all_d, last_bad;
  logic [DATA_W-1:0] win_prv, win_cur, win_nxt, pix_d;

  always_comb begin
    in_ready   = (state_q != FLUSH);
    is_chan    = (color_in < VOID);
    hit        = valid_in & in_ready & is_chan;
    in_order   = (color_in == 3'(ch_q));
    acc        = hit & in_order;
    bad        = (valid_in & ~in_ready) | (hit & ~in_order);
    end_px     = acc & (ch_q == CH_LAST);
    last_any_d = last_any_q | last_in;
    last_all_d = last_all_q & last_in;
    last_bad   = end_px & (last_any_d != last_all_d);
    win_prv    = prv_q[ch_q];
    win_cur    = cur_q[ch_q];
    // The final pixel has no right neighbour, so it is mirrored from cur.
    win_nxt    = (state_q == FLUSH) ? win_cur : pixel_in;
    pix_d      = filt(mode_q, win_prv, win_cur, win_nxt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      mode_q      <= 2'b00;
      last_any_q  <= 1'b0;
      last_all_q  <= 1'b1;
      pixel_out_q <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      color_out_q <= VOID;
      err_q       <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        prv_q[i] <= '0;
        cur_q[i] <= '0;
      end
    end else begin
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      color_out_q <= VOID;
      if (bad || last_bad) err_q <= 1'b1;
      if (acc) begin
        last_any_q <= end_px ? 1'b0 : last_any_d;
        last_all_q <= end_px ? 1'b1 : last_all_d;
      end
      case (state_q)
        IDLE, FILL: begin
          if (acc) begin
            prv_q[ch_q] <= pixel_in;
            cur_q[ch_q] <= pixel_in;
            if (state_q == IDLE) mode_q <= mode_in;
            if (ch_q == CH_LAST) begin
              ch_q    <= '0;
              state_q <= last_in ? FLUSH : RUN;
            end else begin
              ch_q    <= ch_q + CW'(1);
              state_q <= FILL;
            end
          end
        end
        RUN: begin
          if (acc) begin
            pixel_out_q <= pix_d;
            valid_out_q <= 1'b1;
            color_out_q <= 3'(ch_q);
            prv_q[ch_q] <= cur_q[ch_q];
            cur_q[ch_q] <= pixel_in;
            if (ch_q == CH_LAST) begin
              ch_q <= '0;
              if (last_in) state_q <= FLUSH;
            end else begin
              ch_q <= ch_q + CW'(1);
            end
          end
        end
        FLUSH: begin
          pixel_out_q <= pix_d;
          valid_out_q <= 1'b1;
          last_out_q  <= 1'b1;
          color_out_q <= 3'(ch_q);
          if (ch_q == CH_LAST) begin
            ch_q    <= '0;
            state_q <= IDLE;
          end else begin
            ch_q <= ch_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pixel_out = pixel_out_q;
  assign valid_out = valid_out_q;
  assign color_out = color_out_q;
  assign last_out  = last_out_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_denoise_stream.sv
// Directed bench for denoise_stream: table of whole frames with hand-computed outputs,
// plus sequences for busy-time errors, mid-frame reset and out-of-order channels.
module tb_denoise_stream;

  logic       clk, rst;
  logic [7:0] pixel_in;
  logic       valid_in;
  logic [2:0] color_in;
  logic       last_in;
  logic [1:0] mode_in;
  logic       in_ready;
  logic [7:0] pixel_out;
  logic       valid_out;
  logic [2:0] color_out;
  logic       last_out;
  logic       err;
  logic [1:0] state_dbg;

  denoise_stream #(.DATA_W(8), .CH(3)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(valid_in), .color_in(color_in),
    .last_in(last_in), .mode_in(mode_in), .in_ready(in_ready), .pixel_out(pixel_out),
    .valid_out(valid_out), .color_out(color_out), .last_out(last_out), .err(err),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // scoreboard: every output sample is {last, color, pixel}
  always @(negedge clk) begin
    if (rst && valid_out) begin
      if (exp_q.size() == 0) check("out_unexpected", 32'(valid_out), 32'd0);
      else check("out", 32'({last_out, color_out, pixel_out}), 32'(exp_q.pop_front()));
    end
  end

  typedef struct {
    logic [1:0] mode;
    int         n;
    int         pin[4][3];
    int         pout[4][3];
  } vec_t;

  vec_t vecs[8];

  task automatic push_exp(input int r, input int g, input int b, input logic l);
    exp_q.push_back({l, 3'd0, 8'(r)});
    exp_q.push_back({l, 3'd1, 8'(g)});
    exp_q.push_back({l, 3'd2, 8'(b)});
  endtask

  task automatic drive_sample(input logic [2:0] c, input logic [7:0] v, input logic l,
                              input logic [1:0] m);
    int t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("ready_timeout", 32'(in_ready), 32'd1);
    valid_in = 1'b1;
    color_in = c;
    pixel_in = v;
    last_in  = l;
    mode_in  = m;
    @(negedge clk);
    valid_in = 1'b0;
    color_in = 3'd3;
    last_in  = 1'b0;
  endtask

  task automatic drive_pixel(input int k, input int r, input int g, input int b,
                             input logic l, input logic [1:0] m);
    int px[3];
    px = '{r, g, b};
    for (int c = 0; c < 3; c++) begin
      drive_sample(3'(c), 8'(px[c]), l, m);
      check("valid_timing", 32'(valid_out), 32'(k >= 1));
    end
  endtask

  task automatic wait_flush(input int n);
    int cnt = 0;
    while (!in_ready && cnt < 10) begin
      cnt++;
      @(negedge clk);
    end
    check("flush_len", 32'(cnt), 32'(n));
  endtask

  task automatic run_vector(input int i, input bit poke);
    vec_t v;
    logic [1:0] m;
    v = vecs[i];
    for (int k = 0; k < v.n; k++) push_exp(v.pout[k][0], v.pout[k][1], v.pout[k][2], k == v.n - 1);
    for (int k = 0; k < v.n; k++) begin
      m = (k == 0) ? v.mode : 2'($urandom_range(0, 3));
      drive_pixel(k, v.pin[k][0], v.pin[k][1], v.pin[k][2], k == v.n - 1, m);
    end
    if (poke) begin
      valid_in = 1'b1; color_in = 3'd0; pixel_in = 8'd123; last_in = 1'b0; mode_in = 2'b10;
      @(negedge clk);
      valid_in = 1'b0; color_in = 3'd3;
      check("busy_err", 32'(err), 32'd1);
      wait_flush(2);
    end else begin
      wait_flush(3);
    end
    @(negedge clk);
    #1;
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_pixel", 32'(pixel_out), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_color", 32'(color_out), 32'd3);
    check("rst_last",  32'(last_out),  32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);
    check("rst_err",   32'(err),       32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
  endtask

  initial begin
    vecs[0] = '{mode: 2'd0, n: 4,
                pin:  '{'{10, 1, 5}, '{20, 2, 6}, '{30, 3, 7}, '{40, 4, 8}},
                pout: '{'{10, 1, 5}, '{20, 2, 6}, '{30, 3, 7}, '{40, 4, 8}}};
    vecs[1] = '{mode: 2'd1, n: 4,
                pin:  '{'{10, 77, 77}, '{200, 77, 77}, '{30, 77, 77}, '{40, 77, 77}},
                pout: '{'{10, 77, 77}, '{30, 77, 77},  '{40, 77, 77}, '{40, 77, 77}}};
    vecs[2] = '{mode: 2'd2, n: 3,
                pin:  '{'{0, 255, 255},  '{255, 255, 255}, '{0, 255, 255},  '{0, 0, 0}},
                pout: '{'{64, 255, 255}, '{128, 255, 255}, '{64, 255, 255}, '{0, 0, 0}}};
    vecs[3] = '{mode: 2'd1, n: 1,
                pin:  '{'{9, 99, 199}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}},
                pout: '{'{9, 99, 199}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}}};
    vecs[4] = '{mode: 2'd2, n: 4,
                pin:  '{'{100, 4, 0}, '{0, 8, 0},  '{100, 12, 0}, '{0, 16, 0}},
                pout: '{'{75, 5, 0},  '{50, 8, 0}, '{50, 12, 0},  '{25, 15, 0}}};
    vecs[5] = '{mode: 2'd3, n: 3,
                pin:  '{'{50, 1, 200}, '{60, 2, 100}, '{70, 3, 0}, '{0, 0, 0}},
                pout: '{'{50, 1, 200}, '{60, 2, 100}, '{70, 3, 0}, '{0, 0, 0}}};
    vecs[6] = '{mode: 2'd1, n: 2,
                pin:  '{'{5, 9, 250}, '{9, 5, 250}, '{0, 0, 0}, '{0, 0, 0}},
                pout: '{'{5, 9, 250}, '{9, 5, 250}, '{0, 0, 0}, '{0, 0, 0}}};
    vecs[7] = '{mode: 2'd1, n: 3,
                pin:  '{'{7, 10, 0}, '{3, 20, 0}, '{9, 30, 0}, '{0, 0, 0}},
                pout: '{'{7, 10, 0}, '{7, 20, 0}, '{9, 30, 0}, '{0, 0, 0}}};

    rst = 1'b0; valid_in = 1'b0; color_in = 3'd3; pixel_in = 8'd0; last_in = 1'b0; mode_in = 2'b00;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vector(i, 1'b0);
    check("no_err", 32'(err), 32'd0);

    // frame A bypass with a sample pushed during its flush, then frame B mean
    run_vector(0, 1'b1);
    run_vector(4, 1'b0);
    check("err_sticky", 32'(err), 32'd1);

    // reset in the middle of a running frame
    push_exp(10, 1, 5, 1'b0);
    exp_q.push_back({1'b0, 3'd0, 8'd20});
    drive_pixel(0, 10, 1, 5, 1'b0, 2'b00);
    drive_pixel(1, 20, 2, 6, 1'b0, 2'b00);
    drive_sample(3'd0, 8'd30, 1'b0, 2'b00);
    check("pre_rst_valid", 32'(valid_out), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals();
    check("rst_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_vector(7, 1'b0);
    check("clean_err", 32'(err), 32'd0);

    // G sent where B is expected
    drive_sample(3'd0, 8'd1, 1'b0, 2'b00);
    drive_sample(3'd1, 8'd2, 1'b0, 2'b00);
    drive_sample(3'd1, 8'd3, 1'b0, 2'b00);
    check("order_err", 32'(err), 32'd1);
    @(negedge clk);
    #1;
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
